// File: rtl/nes_pad_reader.sv
// NES-style (4021) gamepad serial front end: drives latch/clock, samples data, registers 8 buttons.
// Optional NES_PAD_SOCD_FILTER_EN clears opposing direction pairs when both are pressed.
module nes_pad_reader #(
   parameter int HALF_PERIOD = 6,
   parameter int POLL_TICKS  = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_data,
   output logic pad_latch,
   output logic pad_clk,
   output logic A,
   output logic B,
   output logic select,
   output logic start,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic pad_valid
);

   localparam int DIV_W  = $clog2(HALF_PERIOD);
   localparam int POLL_W = $clog2(POLL_TICKS + 1);
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(HALF_PERIOD - 1);
   localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_TICKS - 1);

   typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLKH, DONE} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              lat_cnt_q, lat_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        btn_q, btn_d;
   logic              latch_q, latch_d;
   logic              pclk_q, pclk_d;
   logic              valid_q, valid_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              tick;

   function automatic logic [7:0] filter_dirs(input logic [7:0] raw);
      logic [7:0] res;
      res = raw;
`ifdef NES_PAD_SOCD_FILTER_EN
      if (raw[4] && raw[5]) res[5:4] = 2'b00;
      if (raw[6] && raw[7]) res[7:6] = 2'b00;
`endif
      return res;
   endfunction

   assign tick = (div_q == DIV_MAX);

   always_comb begin
      state_d   = state_q;
      div_d     = tick ? '0 : div_q + 1'b1;
      poll_d    = poll_q;
      bit_idx_d = bit_idx_q;
      lat_cnt_d = lat_cnt_q;
      shift_d   = shift_q;
      btn_d     = btn_q;
      sync1_d   = pad_data;
      sync2_d   = sync1_q;

      case (state_q)
         IDLE: begin
            if (tick) begin
               if (poll_q == POLL_MAX) begin
                  poll_d    = '0;
                  bit_idx_d = 3'd0;
                  lat_cnt_d = 1'b0;
                  state_d   = LATCH;
               end else begin
                  poll_d = poll_q + 1'b1;
               end
            end
         end
         LATCH: begin
            if (tick) begin
               if (lat_cnt_q) begin
                  lat_cnt_d = 1'b0;
                  state_d   = SAMPLE;
               end else begin
                  lat_cnt_d = 1'b1;
               end
            end
         end
         SAMPLE: begin
            // Pad data is active-low; store pressed as 1.
            if (tick) begin
               shift_d[bit_idx_q] = ~sync2_q;
               state_d = (bit_idx_q == 3'd7) ? DONE : CLKH;
            end
         end
         CLKH: begin
            if (tick) begin
               bit_idx_d = bit_idx_q + 3'd1;
               state_d   = SAMPLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Output flops load from the next state so they align with it and stay glitch-free.
      latch_d = (state_d == LATCH);
      pclk_d  = (state_d == CLKH);
      valid_d = (state_d == DONE);
      if (state_d == DONE) btn_d = filter_dirs(shift_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         div_q     <= '0;
         poll_q    <= '0;
         bit_idx_q <= 3'd0;
         lat_cnt_q <= 1'b0;
         shift_q   <= 8'd0;
         btn_q     <= 8'd0;
         latch_q   <= 1'b0;
         pclk_q    <= 1'b0;
         valid_q   <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         poll_q    <= poll_d;
         bit_idx_q <= bit_idx_d;
         lat_cnt_q <= lat_cnt_d;
         shift_q   <= shift_d;
         btn_q     <= btn_d;
         latch_q   <= latch_d;
         pclk_q    <= pclk_d;
         valid_q   <= valid_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
      end
   end

   assign pad_latch = latch_q;
   assign pad_clk   = pclk_q;
   assign pad_valid = valid_q;
   assign {right, left, down, up, start, select, B, A} = btn_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader: a behavioural 4021 pad model feeds patterns,
// expected buttons are queued at latch time and popped by a monitor on pad_valid.
module tb_nes_pad_reader;

   localparam int HP = 4;
   localparam int PT = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic pad_data;
   logic pad_latch, pad_clk, pad_valid;
   logic A, B, select, start, up, down, left, right;
   logic [7:0] btn;

   int errors = 0;
   int checks = 0;

   logic [7:0] pat_q[$];
   logic [7:0] exp_q[$];

   logic [7:0] sr = 8'hFF;
   logic       tog = 1'b1;
   logic       tog_val = 1'b0;
   logic       rst_at_edge = 1'b0;

   assign pad_data = tog ? tog_val : sr[0];
   assign btn = {right, left, down, up, start, select, B, A};

   nes_pad_reader #(.HALF_PERIOD(HP), .POLL_TICKS(PT)) dut (
      .clk(clk), .reset(reset), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_clk(pad_clk),
      .A(A), .B(B), .select(select), .start(start),
      .up(up), .down(down), .left(left), .right(right),
      .pad_valid(pad_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rst_at_edge <= reset;

   function automatic logic [7:0] expect_btn(input logic [7:0] p);
      logic [7:0] e;
      e = p;
`ifdef NES_PAD_SOCD_FILTER_EN
      if (p[4] && p[5]) e[5:4] = 2'b00;
      if (p[6] && p[7]) e[7:6] = 2'b00;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Pad model: parallel load while latched, shift toward the data pin on pad_clk rise.
   logic       pm_pl_prev = 1'b0;
   logic       pm_pc_prev = 1'b0;
   logic [7:0] pm_cur = 8'h00;
   logic [7:0] pm_p;
   initial begin
      forever begin
         @(negedge clk);
         tog_val = ~tog_val;
         if (pad_latch && !pm_pl_prev) begin
            if (pat_q.size() > 0) pm_p = pat_q.pop_front();
            else pm_p = 8'($urandom);
            pm_cur = pm_p;
            exp_q.push_back(expect_btn(pm_p));
         end
         if (pad_latch) sr = ~pm_cur;
         else if (pad_clk && !pm_pc_prev) sr = {1'b1, sr[7:1]};
         pm_pl_prev = pad_latch;
         pm_pc_prev = pad_clk;
      end
   end

   // Output monitor: reset state, decode at pad_valid, hold between frames, line exclusivity.
   logic [7:0] mon_held = 8'h00;
   logic       mon_pv_prev = 1'b0;
   logic [7:0] mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_at_edge) begin
            chk("reset_state", {20'd0, pad_latch, pad_clk, pad_valid, btn}, 32'd0);
            mon_held = 8'h00;
         end else begin
            chk("latch_clk_exclusive", {31'd0, pad_latch & pad_clk}, 32'd0);
            if (pad_valid) begin
               chk("valid_single_cycle", {31'd0, mon_pv_prev}, 32'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", 32'd1, 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("decode", {24'd0, btn}, {24'd0, mon_e});
               end
               mon_held = btn;
            end else begin
               chk("hold", {24'd0, btn}, {24'd0, mon_held});
            end
         end
         mon_pv_prev = pad_valid;
      end
   end

   // Timing monitor: frame waveform measured in clk cycles between negedges.
   int   tm_cyc = 0;
   int   tm_lrise, tm_lfall, tm_crise, tm_cfall, tm_valid, tm_nclk;
   logic tm_in_frame = 1'b0, tm_have_valid = 1'b0;
   logic tm_pl = 1'b0, tm_pc = 1'b0, tm_pv = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         tm_cyc++;
         if (!rst_at_edge) begin
            tm_in_frame = 1'b0;
            tm_have_valid = 1'b0;
         end else begin
            if (pad_latch && !tm_pl) begin
               if (tm_have_valid) chk("poll_gap", tm_cyc - tm_valid, PT * HP);
               tm_in_frame = 1'b1;
               tm_nclk = 0;
               tm_lrise = tm_cyc;
            end
            if (!pad_latch && tm_pl && tm_in_frame) begin
               chk("latch_width", tm_cyc - tm_lrise, 2 * HP);
               tm_lfall = tm_cyc;
            end
            if (pad_clk && !tm_pc && tm_in_frame) begin
               chk("clk_low", (tm_nclk == 0) ? tm_cyc - tm_lfall : tm_cyc - tm_cfall, HP);
               tm_nclk++;
               tm_crise = tm_cyc;
            end
            if (!pad_clk && tm_pc && tm_in_frame) begin
               chk("clk_high", tm_cyc - tm_crise, HP);
               tm_cfall = tm_cyc;
            end
            if (pad_valid && !tm_pv && tm_in_frame) begin
               chk("clk_count", tm_nclk, 7);
               chk("done_latency", tm_cyc - tm_cfall, HP);
               tm_have_valid = 1'b1;
               tm_valid = tm_cyc;
               tm_in_frame = 1'b0;
            end
         end
         tm_pl = pad_latch;
         tm_pc = pad_clk;
         tm_pv = pad_valid;
      end
   end

   task automatic wait_valids(input int n);
      int got;
      got = 0;
      for (int c = 0; c < 200 * n && got < n; c++) begin
         @(negedge clk);
         if (pad_valid) got++;
      end
      chk("valid_count", got, n);
   endtask

   // Stimulus
   int   k;
   int   nrise;
   logic st_pc_prev;
   initial begin
      reset = 1'b0;
      tog = 1'b1;
      pat_q.push_back(8'h01);
      pat_q.push_back(8'hA5);
      pat_q.push_back(8'hFF);
      pat_q.push_back(8'h00);
      pat_q.push_back(8'h70);
      pat_q.push_back(8'h10);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      tog = 1'b0;

      k = 0;
      for (int c = 1; c <= 4 * PT * HP; c++) begin
         @(negedge clk);
         if (pad_latch) begin
            k = c;
            break;
         end
      end
      chk("first_latch_delay", k, PT * HP);

      wait_valids(6);

      // Abort a frame during its 4th pad_clk high phase.
      pat_q.push_back(8'h33);
      nrise = 0;
      st_pc_prev = pad_clk;
      for (int c = 0; c < 400 && nrise < 4; c++) begin
         @(negedge clk);
         if (pad_clk && !st_pc_prev) nrise++;
         st_pc_prev = pad_clk;
      end
      chk("midframe_reached", nrise, 4);
      reset = 1'b0;
      @(negedge clk);
      exp_q.delete();
      pat_q.delete();
      chk("midrst_buttons", {24'd0, btn}, 32'd0);
      chk("midrst_pad_clk", {31'd0, pad_clk}, 32'd0);
      @(negedge clk);
      pat_q.push_back(8'h40);
      reset = 1'b1;
      wait_valids(1);

      pat_q.push_back(8'hF0);
      pat_q.push_back(8'h30);
      pat_q.push_back(8'hC0);
      for (int i = 0; i < 10; i++) pat_q.push_back(8'($urandom_range(0, 255)));
      wait_valids(13);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Serial front end for an NES-style gamepad (4021 shift-register protocol).
- Drives the pad's latch and clock lines, samples the pad's serial data line, and presents the eight decoded buttons as registered, active-high levels.
- These levels feed the player logic's A, B, select, start, up, down, left and right inputs.
- Polls continuously; all eight outputs update atomically once per completed frame.

Parameters:
- HALF_PERIOD, 6, clk cycles per pad-clock half period (tick spacing); must be >= 3.
- POLL_TICKS, 1000, ticks from the end of one frame to the start of the next latch pulse; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- pad_data  input  1  serial data from pad, active-low (0 = pressed), asynchronous
- pad_latch  output  1  pad latch/strobe, active-high
- pad_clk  output  1  pad shift clock; pad shifts on its rising edge
- A, B, select, start, up, down, left, right  output  1 each  decoded buttons, active-high
- pad_valid  output  1  one-cycle pulse when the button outputs update

Behaviour:
- Reset: applies on the clk edge where reset==0; all of the following are 0 after that edge:
  - pad_latch, pad_clk, all buttons, pad_valid
  - tick divider, poll counter, bit index, shift register
  - state = IDLE
- Reset mid-frame aborts the frame; no partial data ever reaches the outputs.
- Synchroniser: pad_data passes through a 2-flop synchroniser; the FSM uses only the synchronised value.
- Tick divider:
  - Free-running counter 0..HALF_PERIOD-1.
  - tick = 1 for one clk when the counter == HALF_PERIOD-1.
  - First tick after reset occurs HALF_PERIOD cycles after reset release.
- FSM (state advances only on tick except DONE):
  - IDLE: pad_latch=0, pad_clk=0. Poll counter increments on tick. On the tick where it == POLL_TICKS-1: clear it, bit_idx=0, go LATCH.
  - LATCH: pad_latch=1 for exactly 2 ticks, then go SAMPLE.
  - SAMPLE: pad_latch=0, pad_clk=0 for 1 tick. On that tick, shift[bit_idx] = ~pad_data_sync. If bit_idx==7, go DONE; else go CLKH.
  - CLKH: pad_clk=1 for 1 tick. On leaving, bit_idx increments and the FSM goes SAMPLE.
  - DONE: single clk, no tick needed. Copy shift to outputs, pulse pad_valid=1, go IDLE.
- Bit order: bit0=A, 1=B, 2=select, 3=start, 4=up, 5=down, 6=left, 7=right.
- Frame length, LATCH entry to DONE: 2 + 8 + 7 = 17 ticks, then 1 clk.
- Outputs:
  - pad_latch and pad_clk are registered, glitch-free, and never high simultaneously.
  - Button outputs hold their value between frames and change only in the DONE cycle.
  - pad_valid is high only in the DONE cycle.
- Bits beyond 8 are never clocked.
- A disconnected pad (data pulled high) yields all buttons 0.

Optional Feature:
- Macro: NES_PAD_SOCD_FILTER_EN.
- Defined: applied at the DONE copy, so the player never sees contradictory directions.
  - If up and down are both pressed, both outputs are 0.
  - If left and right are both pressed, both outputs are 0.
  - Other buttons are unaffected.
- Undefined: raw decoded bits are passed unchanged.

Test Plan:
- Reset hold: reset=0 for 5 clk with pad_data toggling -> all outputs 0, no pad_latch pulse. Release reset -> first pad_latch rise occurs exactly POLL_TICKS*HALF_PERIOD clk after release.
- Timing (HALF_PERIOD=4, POLL_TICKS=4):
  - pad_latch high 8 clk.
  - 7 pad_clk pulses, each 4 clk high with 4 clk low between.
  - pad_valid pulses one clk after the 8th sample tick.
  - Next pad_latch rise 16 clk after pad_valid.
- Decode: pad model with only A pressed (0x01) -> A=1, others 0. Pattern 0xA5 -> A=1, B=0, select=1, start=0, up=0, down=1, left=0, right=1 at pad_valid.
- Hold/update: first frame 0xFF, second frame 0x00 -> outputs all 1 until the second pad_valid, then all 0 in the same cycle as the pulse. No intermediate values are ever visible.
- Mid-frame reset: reset=0 during the 4th CLKH with prior outputs 0x10 -> outputs 0 and pad_clk 0 next edge. After release, the first full frame with 0x40 yields left=1 only.
- SOCD: pad pattern up+down+left (0x70):
  - With NES_PAD_SOCD_FILTER_EN -> up=0, down=0, left=1.
  - Without it -> up=1, down=1, left=1.
